mul_dot_accumulator: RTL and testbench
======================================

// Module: mul_dot_accumulator
// PURPOSE
//  Downstream consumer of integrationMult: accumulates a run of signed 64-bit
//  products into a wide signed sum (dot product / MAC tail). Host programs a run
//  length with start. Products arrive qualified by in_valid. The final sum is
//  presented on a valid/ready output register.
// PARAMETERS
//  PROD_W    64  product width (matches multiplier out)
//  ACC_W     72  accumulator/result width, >= PROD_W; product sign-extended
//  CNT_W     8   run-length counter width (max run 2**CNT_W-1)
//  SATURATE  1   1: clamp on signed overflow; 0: two's-complement wrap
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       async, active-high reset
//  en         in   1       global enable; 0 freezes all state (as the multiplier)
//  start      in   1       begin new run (sampled only when ready to accept)
//  length     in   CNT_W   number of products in run, latched on start
//  in_valid   in   1       product is valid this cycle
//  product    in   PROD_W  signed product from integrationMult
//  out_valid  out  1       result valid, held until accepted
//  out_ready  in   1       consumer accepts result
//  result     out  ACC_W   signed final sum
//  overflow   out  1       sticky per run: any step overflowed ACC_W
//  busy       out  1       run in progress (ACCUM state)
//  drop       out  1       1-cycle pulse: in_valid seen outside ACCUM, product discarded
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; acc, count, result = 0;
//    out_valid, overflow, busy, drop = 0.
//  - en=0: no register changes (state, acc, count, result, flags).
//    drop is forced 0. Reset still overrides.
//  - States: IDLE, ACCUM, DONE.
//  - IDLE:
//    - start & length>0: acc=0, count=0, overflow=0, latch length -> ACCUM.
//    - start & length==0: result=0, overflow=0 -> DONE.
//  - ACCUM, busy=1; start ignored. Each in_valid cycle:
//    - acc = acc + sext(product) via the adder; count++.
//    - overflow |= ovf.
//    - On the length-th valid product: result=new sum -> DONE.
//      out_valid=1 the cycle after the last product is accepted (latency 1).
//  - DONE: out_valid=1; result and overflow held stable while out_ready=0.
//    - out_valid & out_ready: -> IDLE, out_valid=0 next cycle.
//    - If start is also high that cycle, the new run is accepted directly
//      (same rules as IDLE), back-to-back with no bubble.
//  - in_valid in IDLE/DONE: product discarded; drop=1 for that cycle.
//  - Adder: signed ACC_W add; ovf = operands same sign & sum sign differs.
//    - SATURATE=1: clamp to +(2^(ACC_W-1)-1) / -2^(ACC_W-1); accumulation continues.
//    - SATURATE=0: wrap, flag only.
//  - Reset mid-run: run abandoned; no partial result emitted.
// STRUCTURE
//  - mul_acc_pkg: state encoding (IDLE/ACCUM/DONE), default widths, SAT_MAX/SAT_MIN
//    as functions of ACC_W.
//  - Sub-module mul_acc_sat_adder (combinational: a, b, SATURATE ->
//    sum, ovf), instantiated once.
// TESTING (clk period 2T, compare after settle; product fed directly or via integrationMult)
//  1. start, length=3; products 5, -2, 7 on consecutive cycles
//     -> out_valid 1 cycle after 7; result=10; overflow=0; busy low in DONE.
//  2. length=2; products 0x7FFF_FFFF_FFFF_FFFF twice (ACC_W=72)
//     -> result=0x00_FFFF_FFFF_FFFF_FFFE; overflow=0.
//  3. ACC_W=64, SATURATE=1; products 0x7FFF_FFFF_FFFF_FFFF, 1, -1
//     -> result=0x7FFF_FFFF_FFFF_FFFE; overflow=1.
//     Same stimulus with SATURATE=0 -> result=0x7FFF_FFFF_FFFF_FFFF (wrapped
//     then restored); overflow=1.
//  4. Backpressure: out_ready=0 for 5 cycles in DONE; in_valid pulses with product=99
//     -> result/out_valid stable; drop pulses each cycle.
//     out_ready=1 with start, length=1 -> next run starts, no idle cycle.
//  5. Reset asserted mid-edge after 2 of 4 products
//     -> all outputs 0 immediately; new run length=1, product=-4 -> result=-4.
//  6. en=0 for 3 cycles mid-run with in_valid=1 -> no count/acc change, drop=0.
//     Separately, start with length=0 -> out_valid next cycle, result=0.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// Shared definitions for the product accumulator: FSM states, default widths,
// and the saturation bounds as functions of the accumulator width.
package mul_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam int PROD_W_DEF = 64;
    localparam int ACC_W_DEF  = 72;
    localparam int CNT_W_DEF  = 8;

    // Bounds are built in a generously wide vector and sliced by the user to ACC_W.
    localparam int SAT_FN_W = 256;

    function automatic logic [SAT_FN_W-1:0] sat_min(input int acc_w);
        return SAT_FN_W'(1) << (acc_w - 1);
    endfunction

    function automatic logic [SAT_FN_W-1:0] sat_max(input int acc_w);
        return sat_min(acc_w) - SAT_FN_W'(1);
    endfunction

endpackage

// File: rtl/mul_acc_sat_adder.sv
// Combinational signed adder with overflow detect and optional clamp to the
// most positive / most negative ACC_W-bit value.
module mul_acc_sat_adder
    import mul_acc_pkg::*;
#(
    parameter int ACC_W    = ACC_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    localparam logic [SAT_FN_W-1:0] MAX_FULL = sat_max(ACC_W);
    localparam logic [SAT_FN_W-1:0] MIN_FULL = sat_min(ACC_W);
    localparam logic [ACC_W-1:0]    SAT_MAX  = MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]    SAT_MIN  = MIN_FULL[ACC_W-1:0];

    logic [ACC_W-1:0] raw;

    // Overflow direction follows the shared operand sign.
    always_comb begin
        raw = a + b;
        ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw[ACC_W-1] != a[ACC_W-1]);
        sum = raw;
        if (SATURATE && ovf) begin
            sum = a[ACC_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mul_dot_accumulator.sv
// Accumulates a programmed-length run of signed products into a wide sum and
// presents the final value on a valid/ready output register.
module mul_dot_accumulator
    import mul_acc_pkg::*;
#(
    parameter int PROD_W   = PROD_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic [CNT_W-1:0]  length,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  result,
    output logic              overflow,
    output logic              busy,
    output logic              drop
);

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] count_next;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             step_ovf;
    logic             start_ok;

    assign prod_ext   = ACC_W'($signed(product));
    assign count_next = count + CNT_W'(1);

    // A new run is taken from IDLE, or from DONE in the same cycle the result is handed off.
    assign start_ok = start && ((state == IDLE) || ((state == DONE) && out_ready));

    assign drop = en && !reset && in_valid && (state != ACCUM);

    mul_acc_sat_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_adder (
        .a   (acc),
        .b   (prod_ext),
        .sum (sum),
        .ovf (step_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            run_len   <= '0;
            result    <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b0;
        end else if (en) begin
            if (start_ok) begin
                overflow <= 1'b0;
                if (length != '0) begin
                    acc       <= '0;
                    count     <= '0;
                    run_len   <= length;
                    state     <= ACCUM;
                    busy      <= 1'b1;
                    out_valid <= 1'b0;
                end else begin
                    result    <= '0;
                    state     <= DONE;
                    busy      <= 1'b0;
                    out_valid <= 1'b1;
                end
            end else begin
                case (state)
                    ACCUM: begin
                        if (in_valid) begin
                            acc      <= sum;
                            count    <= count_next;
                            overflow <= overflow | step_ovf;
                            if (count_next == run_len) begin
                                result    <= sum;
                                state     <= DONE;
                                busy      <= 1'b0;
                                out_valid <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_dot_accumulator.sv
// Randomized and directed bench for mul_dot_accumulator: one 72-bit saturating
// instance and two 64-bit instances (saturating and wrapping) share the stimulus.
module tb_mul_dot_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        start;
    logic [7:0]  length;
    logic        in_valid;
    logic [63:0] product;
    logic        out_ready;

    logic [2:0]  ov;
    logic [2:0]  ovf;
    logic [2:0]  busy;
    logic [2:0]  drop;
    logic [71:0] res0;
    logic [63:0] res1;
    logic [63:0] res2;

    int passCount  = 0;
    int checkCount = 0;

    int W[3]   = '{72, 64, 64};
    bit SAT[3] = '{1'b1, 1'b1, 1'b0};

    logic signed [127:0] macc[3];
    bit                  mov[3];
    logic [63:0]         prodQ[$];

    always #5 clk = ~clk;

    mul_dot_accumulator #(.ACC_W(72), .SATURATE(1'b1)) dut72 (
        .clk(clk), .reset(reset), .en(en), .start(start), .length(length),
        .in_valid(in_valid), .product(product), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res0), .overflow(ovf[0]), .busy(busy[0]), .drop(drop[0])
    );

    mul_dot_accumulator #(.ACC_W(64), .SATURATE(1'b1)) dut64s (
        .clk(clk), .reset(reset), .en(en), .start(start), .length(length),
        .in_valid(in_valid), .product(product), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res1), .overflow(ovf[1]), .busy(busy[1]), .drop(drop[1])
    );

    mul_dot_accumulator #(.ACC_W(64), .SATURATE(1'b0)) dut64w (
        .clk(clk), .reset(reset), .en(en), .start(start), .length(length),
        .in_valid(in_valid), .product(product), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res2), .overflow(ovf[2]), .busy(busy[2]), .drop(drop[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: exact integer sum, then clamp or wrap into the instance width.
    function automatic void modelClear();
        for (int i = 0; i < 3; i++) begin
            macc[i] = '0;
            mov[i]  = 1'b0;
        end
    endfunction

    function automatic void modelStep(input logic [63:0] p);
        logic signed [127:0] ps;
        logic signed [127:0] exact;
        logic signed [127:0] maxv;
        logic signed [127:0] minv;
        logic signed [127:0] span;
        ps = 128'($signed(p));
        for (int i = 0; i < 3; i++) begin
            span  = 128'sd1 <<< W[i];
            maxv  = (128'sd1 <<< (W[i] - 1)) - 128'sd1;
            minv  = -(128'sd1 <<< (W[i] - 1));
            exact = macc[i] + ps;
            if (exact > maxv) begin
                mov[i]  = 1'b1;
                macc[i] = SAT[i] ? maxv : exact - span;
            end else if (exact < minv) begin
                mov[i]  = 1'b1;
                macc[i] = SAT[i] ? minv : exact + span;
            end else begin
                macc[i] = exact;
            end
        end
    endfunction

    function automatic logic [127:0] expRes(input int i);
        logic [127:0] mask;
        mask = (128'd1 << W[i]) - 128'd1;
        return macc[i] & mask;
    endfunction

    function automatic logic [127:0] obsRes(input int i);
        case (i)
            0:       return {56'd0, res0};
            1:       return {64'd0, res1};
            default: return {64'd0, res2};
        endcase
    endfunction

    task automatic checkResults(input string tag);
        checkOutput({tag, "_valid"}, ov, 3'b111);
        checkOutput({tag, "_busy"}, busy, 3'b000);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_result%0d", tag, i), obsRes(i), expRes(i));
            checkOutput($sformatf("%s_ovf%0d", tag, i), ovf[i], mov[i]);
        end
    endtask

    task automatic acceptResult(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, "_accepted"}, ov, 3'b000);
    endtask

    // Runs prodQ through the DUTs, optionally issuing the start, with random idle gaps.
    task automatic applyStimulus(input string tag, input int n, input bit doStart, input bit accept);
        modelClear();
        if (doStart) begin
            start  = 1'b1;
            length = 8'(n);
            tick();
            start = 1'b0;
            if (n > 0) checkOutput({tag, "_busy_start"}, busy, 3'b111);
        end
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            product  = prodQ[k];
            #1;
            checkOutput({tag, "_nodrop"}, drop, 3'b000);
            tick();
            modelStep(prodQ[k]);
            if (k < n - 1) checkOutput({tag, "_ov_mid"}, ov, 3'b000);
        end
        in_valid = 1'b0;
        checkResults(tag);
        if (accept) acceptResult(tag);
    endtask

    function automatic logic [63:0] randProduct();
        int v;
        case ($urandom_range(0, 3))
            0: begin
                v = int'($urandom_range(0, 200)) - 100;
                return 64'(v);
            end
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        reset = 1'b1; en = 1'b1; start = 1'b0; length = '0;
        in_valid = 1'b0; product = '0; out_ready = 1'b0;
        tick();
        tick();
        checkOutput("rst_valid", ov, 3'b000);
        checkOutput("rst_busy", busy, 3'b000);
        checkOutput("rst_ovf", ovf, 3'b000);
        checkOutput("rst_drop", drop, 3'b000);
        checkOutput("rst_result", res0, 72'd0);
        reset = 1'b0;
        tick();

        // Basic three-product run.
        prodQ = '{64'd5, -64'sd2, 64'd7};
        applyStimulus("t1", 3, 1'b1, 1'b0);
        checkOutput("t1_const", res0, 72'd10);
        acceptResult("t1");

        // Two maximum positive products: fits in 72 bits, overflows 64.
        prodQ = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
        applyStimulus("t2", 2, 1'b1, 1'b0);
        checkOutput("t2_const", res0, 72'h00_FFFF_FFFF_FFFF_FFFE);
        acceptResult("t2");

        prodQ = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
        applyStimulus("t3", 3, 1'b1, 1'b0);
        checkOutput("t3_sat_const", res1, 64'h7FFF_FFFF_FFFF_FFFE);
        checkOutput("t3_wrap_const", res2, 64'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("t3_ovf_const", ovf[2:1], 2'b11);
        acceptResult("t3");

        // Backpressure in DONE with stray products, then back-to-back restart.
        prodQ = '{64'd11, 64'd22};
        applyStimulus("t4", 2, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            product  = 64'd99;
            #1;
            checkOutput("t4_drop", drop, 3'b111);
            tick();
            checkOutput("t4_hold_valid", ov, 3'b111);
            checkOutput("t4_hold_result", res0, 72'd33);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        length    = 8'd1;
        tick();
        start     = 1'b0;
        out_ready = 1'b0;
        checkOutput("t4_b2b_busy", busy, 3'b111);
        checkOutput("t4_b2b_valid", ov, 3'b000);
        prodQ = '{64'd42};
        applyStimulus("t4b", 1, 1'b0, 1'b1);

        // Asynchronous reset in the middle of a run.
        start  = 1'b1;
        length = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            product  = 64'd1000;
            tick();
        end
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("t5_rst_valid", ov, 3'b000);
        checkOutput("t5_rst_busy", busy, 3'b000);
        checkOutput("t5_rst_ovf", ovf, 3'b000);
        checkOutput("t5_rst_result", res1, 64'd0);
        reset = 1'b0;
        prodQ = '{-64'sd4};
        applyStimulus("t5", 1, 1'b1, 1'b0);
        checkOutput("t5_const", res0, 72'hFF_FFFF_FFFF_FFFF_FFFC);
        acceptResult("t5");

        // Enable low mid-run freezes everything and suppresses drop.
        prodQ = '{64'd3, 64'd4, 64'd5};
        modelClear();
        start  = 1'b1;
        length = 8'd3;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        product  = prodQ[0];
        tick();
        modelStep(prodQ[0]);
        en      = 1'b0;
        product = 64'd123;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("t6_en_drop", drop, 3'b000);
            tick();
            checkOutput("t6_en_busy", busy, 3'b111);
            checkOutput("t6_en_valid", ov, 3'b000);
        end
        en = 1'b1;
        for (int k = 1; k < 3; k++) begin
            product = prodQ[k];
            tick();
            modelStep(prodQ[k]);
            if (k == 1) checkOutput("t6_ov_mid", ov, 3'b000);
        end
        in_valid = 1'b0;
        checkResults("t6");
        checkOutput("t6_const", res0, 72'd12);
        acceptResult("t6");

        // Zero-length run completes immediately with a zero result.
        prodQ = {};
        applyStimulus("t6z", 0, 1'b1, 1'b1);

        // Random runs.
        for (int r = 0; r < 20; r++) begin
            int n;
            n = int'($urandom_range(1, 6));
            prodQ = {};
            for (int k = 0; k < n; k++) prodQ.push_back(randProduct());
            applyStimulus($sformatf("rnd%0d", r), n, 1'b1, 1'b1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
